dsm_feeder: RTL and testbench

Sample scheduler placed in front of the second-order delta-sigma modulator (`dsm`). It accepts 16-bit signed PCM over a valid/ready stream, buffers it in a small FIFO, and presents exactly one sample to the modulator's `pcm` input every `OSR` modulator clocks. It primes the buffer before playback, clamps samples to the modulator's stable 14-bit range, and decays the output toward zero on underrun.

---
 rtl/dsm_feeder.sv | 159 +++++++++++++++
 tb/tb_dsm_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_feeder.sv
// Sample scheduler for the delta-sigma modulator: buffers clamped PCM in a small FIFO
// and releases one sample every OSR modulator clocks, decaying toward zero when starved.
module dsm_feeder #(
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME_LVL  = FIFO_DEPTH / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [15:0]                   in_pcm,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [15:0]                   pcm_out,
    output logic                          sample_tick,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(OSR);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STARVE} state_t;

    state_t                state, state_next;
    logic signed [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic [CW-1:0]         cnt;
    logic signed [15:0]    pcm_r;
    logic [15:0]           under_r;
    logic signed [15:0]    in_s, clamped;
    logic                  push, pop, decay, flush, tick;

    // Valid/ready: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    assign in_ready     = (state != IDLE) && (level != LW'(FIFO_DEPTH));
    assign tick         = (cnt == CW'(OSR - 1)) && ((state == RUN) || (state == STARVE));
    assign sample_tick  = tick;
    assign running      = (state == RUN);
    assign fifo_level   = level;
    assign pcm_out      = pcm_r;
    assign underrun_cnt = under_r;

    // The modulator only uses pcm[13:0], so saturate to the 14-bit signed range.
    assign in_s = $signed(in_pcm);
    always_comb begin
        clamped = in_s;
        if (in_s > 16'sh1FFF)
            clamped = 16'sh1FFF;
        else if (in_s < -16'sh2000)
            clamped = -16'sh2000;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        decay      = 1'b0;
        flush      = 1'b0;
        if (state != IDLE && !enable) begin
            flush      = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (enable) state_next = PRIME;
                PRIME: if (level >= LW'(PRIME_LVL)) begin
                    pop        = 1'b1;
                    state_next = RUN;
                end
                RUN: if (tick) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        decay      = 1'b1;
                        state_next = STARVE;
                    end
                end
                STARVE: if (tick) begin
                    if (level >= LW'(PRIME_LVL)) begin
                        pop        = 1'b1;
                        state_next = RUN;
                    end else begin
                        decay = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A push offered on the flush edge is dropped.
    assign push = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= clamped;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (!push && pop)
                level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcm_r <= '0;
        else if (flush || state == IDLE)
            pcm_r <= '0;
        else if (pop)
            pcm_r <= mem[rd_ptr];
        else if (decay)
            pcm_r <= pcm_r >>> 1;
    end

    // Period counter keeps running through STARVE so resumed output stays phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (flush || state == IDLE || state == PRIME)
            cnt <= '0;
        else if (cnt == CW'(OSR - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            under_r <= '0;
        else if (decay && under_r != 16'hFFFF)
            under_r <= under_r + 16'd1;
    end

endmodule

// File: tb/tb_dsm_feeder.sv
// Bench for dsm_feeder: a queue-based reference model checked every cycle, plus
// directed literal checks for priming, clamp, underrun decay, enable drop and reset.
module tb_dsm_feeder;

    localparam int OSR   = 4;
    localparam int DEPTH = 4;
    localparam int PRIME = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_pcm;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pcm_out;
    logic        sample_tick;
    logic        running;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dsm_feeder #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PRIME)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_pcm       (in_pcm),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pcm_out      (pcm_out),
        .sample_tick  (sample_tick),
        .running      (running),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: playback mode, sample queue, phase within the sample period.
    // mode 0 = idle, 1 = priming, 2 = playing, 3 = starved.
    logic [15:0]        exp_q[$];
    int                 m_mode  = 0;
    int                 m_phase = 0;
    logic signed [15:0] m_pcm   = 16'sd0;
    logic [15:0]        m_under = 16'd0;

    function automatic logic m_ready();
        return (m_mode != 0) && (exp_q.size() != DEPTH);
    endfunction

    function automatic logic m_tick();
        return (m_mode >= 2) && (m_phase == OSR - 1);
    endfunction

    function automatic logic [15:0] clamp(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v > 8191)  return 16'h1FFF;
        if (v < -8192) return 16'hE000;
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin : model_step
        logic do_push;
        logic tck;
        int   old_mode;
        if (rst) begin
            exp_q.delete();
            m_mode  = 0;
            m_phase = 0;
            m_pcm   = 16'sd0;
            m_under = 16'd0;
        end else begin
            do_push  = in_valid && m_ready() && enable;
            tck      = m_tick();
            old_mode = m_mode;
            if (m_mode != 0 && !enable) begin
                exp_q.delete();
                m_mode  = 0;
                m_pcm   = 16'sd0;
                m_phase = 0;
            end else begin
                if (old_mode >= 2)
                    m_phase = (m_phase + 1) % OSR;
                case (old_mode)
                    0: if (enable) m_mode = 1;
                    1: if (exp_q.size() >= PRIME) begin
                        m_pcm   = exp_q.pop_front();
                        m_mode  = 2;
                        m_phase = 0;
                    end
                    2: if (tck) begin
                        if (exp_q.size() > 0) begin
                            m_pcm = exp_q.pop_front();
                        end else begin
                            m_mode  = 3;
                            m_pcm   = m_pcm >>> 1;
                            m_under = (m_under == 16'hFFFF) ? m_under : m_under + 16'd1;
                        end
                    end
                    3: if (tck) begin
                        if (exp_q.size() >= PRIME) begin
                            m_pcm  = exp_q.pop_front();
                            m_mode = 2;
                        end else begin
                            m_pcm   = m_pcm >>> 1;
                            m_under = (m_under == 16'hFFFF) ? m_under : m_under + 16'd1;
                        end
                    end
                    default: ;
                endcase
                if (do_push)
                    exp_q.push_back(clamp(in_pcm));
            end
        end
    end

    always @(negedge clk) begin
        check("pcm_out",      pcm_out,               m_pcm);
        check("fifo_level",   16'(fifo_level),       16'(exp_q.size()));
        check("in_ready",     16'(in_ready),         16'(m_ready()));
        check("sample_tick",  16'(sample_tick),      16'(m_tick()));
        check("running",      16'(running),          16'(m_mode == 2));
        check("underrun_cnt", underrun_cnt,          m_under);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int density;
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_pcm   = 16'd0;
        #1;
        check("rst_pcm",      pcm_out,          16'd0);
        check("rst_ready",    16'(in_ready),    16'd0);
        check("rst_level",    16'(fifo_level),  16'd0);
        check("rst_under",    underrun_cnt,     16'd0);
        step(2);
        rst = 1'b0;
        step(3);
        check("idle_pcm",     pcm_out,          16'd0);
        check("idle_ready",   16'(in_ready),    16'd0);
        check("idle_running", 16'(running),     16'd0);

        // Priming and pacing
        enable = 1'b1;
        step(1);
        check("prime_ready",  16'(in_ready),    16'd1);
        in_valid = 1'b1; in_pcm = 16'd100; step(1);
        in_pcm = 16'd200; step(1);
        check("prime_wait",   16'(running),     16'd0);
        check("prime_level",  16'(fifo_level),  16'd2);
        in_pcm = 16'd300; step(1);
        in_valid = 1'b0;
        check("run_rise",     16'(running),     16'd1);
        check("first_pcm",    pcm_out,          16'd100);
        check("first_level",  16'(fifo_level),  16'd2);
        step(3);
        check("tick_phase",   16'(sample_tick), 16'd1);
        check("hold_pcm",     pcm_out,          16'd100);
        step(1);
        check("second_pcm",   pcm_out,          16'd200);
        check("second_tick",  16'(sample_tick), 16'd0);
        step(4);
        check("third_pcm",    pcm_out,          16'd300);
        step(4);
        check("starve_pcm",   pcm_out,          16'd150);
        check("starve_under", underrun_cnt,     16'd1);

        // Clamp
        enable = 1'b0; step(1);
        check("drop_pcm",     pcm_out,          16'd0);
        check("drop_ready",   16'(in_ready),    16'd0);
        check("drop_under",   underrun_cnt,     16'd1);
        enable = 1'b1; step(1);
        in_valid = 1'b1; in_pcm = 16'h7FFF; step(1);
        in_pcm = 16'h8000; step(1);
        in_pcm = 16'd5; step(1);
        in_valid = 1'b0;
        check("clamp_pos",    pcm_out,          16'h1FFF);
        step(4);
        check("clamp_neg",    pcm_out,          16'hE000);
        step(4);
        check("clamp_pass",   pcm_out,          16'd5);

        // Full FIFO under continuous offer
        in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_pcm = 16'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        step(24);

        // Mid-stream reset, then underrun decay and resume
        in_valid = 1'b1; in_pcm = 16'd42;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pcm",   pcm_out,         16'd0);
        check("mid_rst_ready", 16'(in_ready),   16'd0);
        check("mid_rst_level", 16'(fifo_level), 16'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1);
        in_valid = 1'b1; in_pcm = 16'd64; step(2);
        in_valid = 1'b0;
        step(1);
        check("ur_first",     pcm_out,          16'd64);
        step(4);
        check("ur_second",    pcm_out,          16'd64);
        step(4);
        check("ur_32",        pcm_out,          16'd32);
        check("ur_cnt1",      underrun_cnt,     16'd1);
        step(4);
        check("ur_16",        pcm_out,          16'd16);
        check("ur_cnt2",      underrun_cnt,     16'd2);
        step(4);
        check("ur_8",         pcm_out,          16'd8);
        check("ur_cnt3",      underrun_cnt,     16'd3);
        in_valid = 1'b1; in_pcm = 16'd1000; step(1);
        in_pcm = 16'd2000; step(1);
        in_valid = 1'b0;
        step(1);
        check("resume_tick",  16'(sample_tick), 16'd1);
        step(1);
        check("resume_pcm",   pcm_out,          16'd1000);
        check("resume_run",   16'(running),     16'd1);

        // Enable drop at level 3 in RUN
        in_valid = 1'b1; in_pcm = 16'd7; step(1);
        in_pcm = 16'd8; step(1);
        in_valid = 1'b0;
        check("en_lvl3",      16'(fifo_level),  16'd3);
        enable = 1'b0; step(1);
        check("en_level",     16'(fifo_level),  16'd0);
        check("en_pcm",       pcm_out,          16'd0);
        check("en_ready",     16'(in_ready),    16'd0);
        enable = 1'b1; step(1);
        check("reen_ready",   16'(in_ready),    16'd1);
        check("reen_running", 16'(running),     16'd0);

        // Randomized traffic at varying producer densities
        for (int blk = 0; blk < 10; blk++) begin
            density = $urandom_range(0, 4);
            for (int i = 0; i < 300; i++) begin
                in_valid = ($urandom_range(0, 3) < density);
                in_pcm   = 16'($urandom);
                enable   = ($urandom_range(0, 149) != 0);
                if ($urandom_range(0, 999) == 0) rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end
        in_valid = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
